// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: width default, FSM encoding,
// divide-by-zero quotient and the per-operation control record.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // FSM encoding kept as plain constants for compatibility with older flows
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Quotient reported when the divisor is zero
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    // Per-operation flags captured together with the operands
    typedef struct packed {
        logic q_neg;     // negate quotient at the end
        logic r_neg;     // negate remainder at the end
        logic div_zero;  // divisor was zero
    } div_ctrl_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// trial-subtract the divisor.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    // Shifted remainder needs one extra bit; the subtraction one more for the borrow
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused;

    // Trial subtraction; keep the difference only when it did not borrow
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
        o_qbit  = ~w_diff[WIDTH+1];
        o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

    // The result always fits in WIDTH bits, so these top bits are never needed
    assign w_unused = ^{w_shift[WIDTH], w_diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: restoring radix-2 divider producing quotient (lo)
// and remainder (hi), one quotient bit per cycle, with registered busy/done.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed_div,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_Q   = {WIDTH{DIV_ZERO_Q[0]}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;   // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] r_dvs;
    div_ctrl_t        r_ctrl;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand magnitudes; abs only applies to signed divides
    always_comb begin
        w_neg_a = i_signed_div & i_a[WIDTH-1];
        w_neg_b = i_signed_div & i_b[WIDTH-1];
        w_a_abs = w_neg_a ? -i_a : i_a;
        w_b_abs = w_neg_b ? -i_b : i_b;
    end

    div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Final-step results with sign correction and divide-by-zero override
    always_comb begin
        w_quot     = {r_dvd[WIDTH-2:0], w_step_q};
        w_quot_fix = r_ctrl.div_zero ? ZERO_Q : (r_ctrl.q_neg ? -w_quot : w_quot);
        w_rem_fix  = r_ctrl.r_neg ? -w_step_rem : w_step_rem;
    end

    // FSM, iteration counter, datapath registers and hi/lo result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_ctrl  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // cancel wins over a simultaneous start
                    if (i_start && !i_cancel) begin
                        r_dvd           <= w_a_abs;
                        r_dvs           <= w_b_abs;
                        r_rem           <= '0;
                        r_cnt           <= '0;
                        r_ctrl.q_neg    <= w_neg_a ^ w_neg_b;
                        r_ctrl.r_neg    <= w_neg_a;
                        r_ctrl.div_zero <= (i_b == '0);
                        r_busy          <= 1'b1;
                        r_state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_step_rem;
                        r_dvd <= w_quot;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_hi    <= w_rem_fix;
                            r_lo    <= w_quot_fix;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU; sits beside the execute stage.
- Takes rs/rt operands from the forwarding muxes and produces quotient (lo) and remainder (hi) for the hi/lo register write port.
- Asserts busy so hazard logic stalls F/D/E while a divide is in flight.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand/result width; counter width is clog2(WIDTH).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a divide; sampled only in IDLE
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
cancel  input  1  synchronous abort (flush/exception)
a  input  WIDTH  dividend (rs), sampled with start
b  input  WIDTH  divisor (rt), sampled with start
busy  output  1  registered; high while a divide is in progress
done  output  1  registered; one-cycle pulse when hi/lo are updated
hi  output  WIDTH  remainder register
lo  output  WIDTH  quotient register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and cancel=0 at edge k: latch |a|, |b| (abs only if signed_div), the quotient sign (a[MSB]^b[MSB]) & signed_div, the remainder sign a[MSB] & signed_div, and a div-by-zero flag (b==0).
  - Clear the partial remainder; counter=0; go to BUSY; busy=1 from edge k.
- BUSY:
  - Edges k+1..k+32: one restoring step per edge. Shift {rem,dividend} left 1; trial-subtract |b|; if no borrow, keep the difference and set the quotient bit to 1.
  - Counter increments each step.
  - On the step with counter==WIDTH-1: write sign-corrected results into hi/lo, go to DONE, busy=0, done=1.
  - Total latency: done high in the cycle following edge k+32 (32 cycles after start is captured).
- DONE: lasts one cycle, done=1, then IDLE. A start in DONE is ignored; a start in the next cycle (IDLE) is accepted.
- Sign fix: lo = quotient negated if its sign bit is set; hi = remainder negated if its sign bit is set.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: produces lo=0x80000000, hi=0 naturally; no flag.
- Divide by zero (either signedness): lo=all ones, hi=a as sampled; same 32-cycle latency, done pulses normally.
- hi/lo change only on the final step (or reset) and hold between operations.
- start while BUSY/DONE: ignored; operands are not resampled.
- cancel:
  - In BUSY, next edge → IDLE; busy=0; no done; hi/lo unchanged.
  - cancel with start in IDLE: cancel wins, stay IDLE.
  - cancel in DONE: done still pulses this cycle (results already written); next state IDLE.
- rst mid-operation: immediately returns all outputs to reset values.
- busy is registered. The hazard unit forms the stall as start|busy; the unit itself has no combinational start→busy path.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), DIV_ZERO_Q = all ones, WIDTH default.
- One combinational sub-module, div_step: inputs partial remainder, next dividend bit, divisor; outputs new remainder and quotient bit. Instantiated once per cycle, not unrolled.
- FSM, counter, sign handling and hi/lo registers stay in div_unit.

Test Plan:
- Unsigned 100/7: start, signed_div=0, a=100, b=7 → busy next cycle; done exactly 32 cycles after capture edge; lo=14, hi=2.
- Signed −7/2: a=0xFFFFFFF9, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 7/−2 → lo=0xFFFFFFFD, hi=1.
- 0x80000000 / 0xFFFFFFFF:
  - signed → lo=0x80000000, hi=0.
  - unsigned → lo=0, hi=0x80000000.
- Divide by zero: a=5, b=0, signed and unsigned → lo=0xFFFFFFFF, hi=5, done after 32 cycles.
- Cancel at the 10th BUSY cycle → busy=0 next cycle, no done, hi/lo retain previous values (e.g. 14/2). A new start next cycle (a=9, b=3) → lo=3, hi=0.
- start pulsed while BUSY with different operands → ignored, first result unchanged. rst asserted mid-BUSY → busy=0, done=0, hi=lo=0 next edge.
